// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO stream reader.
//   DefaultDataW : default width of FIFO and stream data
//   state_e      : reader FSM state encoding (Idle=0, Stream=1, Stall=2)
//   state_of()   : maps buffer occupancy + in-flight read to the FSM state
package fifo_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StStall  = 2'd2
  } state_e;

  // Total committed slots decides the state: nothing held, some held, or full.
  function automatic state_e state_of(input logic [1:0] occ, input logic inflight);
    logic [2:0] total;
    total = {1'b0, occ} + {2'b00, inflight};
    case (total)
      3'd0:    return StIdle;
      3'd2:    return StStall;
      default: return StStream;
    endcase
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer.
//   clk, reset     : clock and asynchronous active-low reset
//   push/push_data : write a word at the tail
//   pop            : remove the head word
//   occ            : number of held words (0..2)
//   head           : oldest held word
module fifo_skid_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;
  logic [1:0]        occ_q, occ_d;
  logic              do_push, do_pop;

  // Guards keep the buffer consistent even if a caller misbehaves.
  assign do_pop  = pop & (occ_q != 2'd0);
  assign do_push = push & ((occ_q != 2'd2) | do_pop);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    // Pop first so a same-edge push lands behind any surviving entry.
    if (do_pop) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (do_push) begin
      if (occ_d == 2'd0) begin
        ent0_d = push_data;
      end else begin
        ent1_d = push_data;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = ent0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a synchronous FIFO (one-cycle read latency) and presents the words as a
// valid/ready stream through a two-entry skid buffer.
//   clk, reset   : clock and asynchronous active-low reset
//   enable       : permits new FIFO reads
//   fifo_empty   : FIFO empty flag
//   fifo_dataout : FIFO read data, valid the cycle after Read_En
//   Read_En      : FIFO read strobe (combinational)
//   out_valid    : out_data holds a word
//   out_data     : head of the skid buffer
//   out_ready    : downstream accept
//   word_count   : words accepted downstream (wraps)
//   busy         : FSM not idle
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dataout,
  output logic              Read_En,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_count,
  output logic              busy
);

  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             push, pop;
  logic [2:0]       slots_used;

  fifo_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_dataout),
    .pop       (pop),
    .occ       (occ),
    .head      (out_data)
  );

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  // The word read last cycle arrives now and always lands in the tail.
  assign push      = inflight_q;

  // Slots still committed after this edge; a word leaving this edge frees room
  // for a new read, which keeps the stream at one word per cycle.
  assign slots_used = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  // Gated by reset so no read strobe escapes while reset is held.
  assign Read_En = reset & enable & ~fifo_empty & (slots_used < 3'd2);

  assign occ_next = occ + {1'b0, push} - {1'b0, pop};

  always_comb begin
    inflight_d = Read_En;
    cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, pop};
    state_d    = state_of(occ_next, Read_En);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      state_q    <= StIdle;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  assign word_count = cnt_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural synchronous FIFO.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dataout = '0;
  logic          Read_En;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] word_count;
  logic          busy;

  logic [7:0]  mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        inf_mode = 1'b0;
  int          rd_cnt = 0;
  logic [31:0] got_n = 32'd0;
  logic [7:0]  got [0:255];

  int n_checks = 0;
  int n_err = 0;

  fifo_stream_reader #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_dataout (fifo_dataout),
    .Read_En      (Read_En),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .word_count   (word_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Synchronous FIFO model: registered read data, or an endless source.
  assign fifo_empty = inf_mode ? 1'b0 : (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (Read_En) begin
      rd_cnt <= rd_cnt + 1;
      if (inf_mode) begin
        fifo_dataout <= 8'h5A;
      end else begin
        fifo_dataout <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 8'd1;
      end
    end
    if (out_valid && out_ready) begin
      got[got_n[7:0]] <= out_data;
      got_n           <= got_n + 32'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  function automatic logic [7:0] got_at(input logic [31:0] k);
    return got[k[7:0]];
  endfunction

  logic [31:0] got0;
  int          rd0;
  int          first_v, last_v, n_v;

  initial begin
    // Reset holds everything quiet even with data waiting and enable high.
    mem[0] = 8'hA5;
    wr_ptr = 8'd1;
    enable = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_read_en", 32'(Read_En), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(word_count), 0);
    check("rst_data", 32'(out_data), 0);

    // Single word: read in cycle 0, valid in cycle 2.
    reset = 1'b1;
    #1;
    check("t1_re_c0", 32'(Read_En), 1);
    check("t1_valid_c0", 32'(out_valid), 0);
    tick();
    check("t1_re_c1", 32'(Read_En), 0);
    check("t1_valid_c1", 32'(out_valid), 0);
    check("t1_busy_c1", 32'(busy), 1);
    tick();
    check("t1_valid_c2", 32'(out_valid), 1);
    check("t1_data_c2", 32'(out_data), 32'hA5);
    check("t1_count_c2", 32'(word_count), 0);
    tick();
    check("t1_valid_c3", 32'(out_valid), 0);
    check("t1_count_c3", 32'(word_count), 1);
    check("t1_busy_c3", 32'(busy), 0);
    check("t1_reads", 32'(rd_cnt), 1);

    // Streaming 8 words back to back.
    do_reset();
    got0 = got_n;
    rd0 = rd_cnt;
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    #1;
    first_v = -1;
    last_v = -1;
    n_v = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        n_v++;
      end
      tick();
    end
    check("t2_first_valid", 32'(first_v), 2);
    check("t2_last_valid", 32'(last_v), 9);
    check("t2_valid_cycles", 32'(n_v), 8);
    check("t2_xfers", got_n - got0, 8);
    for (int i = 0; i < 8; i++) check("t2_order", 32'(got_at(got0 + 32'(i))), 32'(i + 1));
    check("t2_count", 32'(word_count), 8);
    check("t2_reads", 32'(rd_cnt - rd0), 8);
    check("t2_state_idle", 32'(dut.state_q), 32'(StIdle));
    check("t2_busy", 32'(busy), 0);

    // Backpressure: only two reads issue while stalled.
    do_reset();
    out_ready = 1'b0;
    got0 = got_n;
    rd0 = rd_cnt;
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    #1;
    repeat (9) tick();
    check("t3_reads_stalled", 32'(rd_cnt - rd0), 2);
    check("t3_valid", 32'(out_valid), 1);
    check("t3_head", 32'(out_data), 32'h01);
    check("t3_re_low", 32'(Read_En), 0);
    check("t3_state_stall", 32'(dut.state_q), 32'(StStall));
    check("t3_no_xfer", got_n - got0, 0);
    out_ready = 1'b1;
    #1;
    repeat (10) tick();
    check("t3_xfers", got_n - got0, 4);
    for (int i = 0; i < 4; i++) check("t3_order", 32'(got_at(got0 + 32'(i))), 32'(i + 1));
    check("t3_count", 32'(word_count), 4);
    check("t3_busy", 32'(busy), 0);

    // Enable drops after one read: in-flight word still delivered.
    do_reset();
    got0 = got_n;
    rd0 = rd_cnt;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    #1;
    check("t4_re_c0", 32'(Read_En), 1);
    tick();
    enable = 1'b0;
    #1;
    check("t4_re_dropped", 32'(Read_En), 0);
    repeat (6) tick();
    check("t4_reads", 32'(rd_cnt - rd0), 1);
    check("t4_xfers", got_n - got0, 1);
    check("t4_word", 32'(got_at(got0)), 32'h11);
    check("t4_count", 32'(word_count), 1);
    check("t4_busy", 32'(busy), 0);
    enable = 1'b1;
    #1;
    repeat (8) tick();
    check("t4_resume_xfers", got_n - got0, 3);
    check("t4_resume_w1", 32'(got_at(got0 + 32'd1)), 32'h22);
    check("t4_resume_w2", 32'(got_at(got0 + 32'd2)), 32'h33);
    check("t4_resume_count", 32'(word_count), 3);

    // Reset mid-stream with the buffer full.
    out_ready = 1'b0;
    push_word(8'h41);
    push_word(8'h42);
    push_word(8'h43);
    push_word(8'h44);
    #1;
    repeat (3) tick();
    check("t5_full_valid", 32'(out_valid), 1);
    check("t5_full_head", 32'(out_data), 32'h41);
    check("t5_pre_count", 32'(word_count), 3);
    reset = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_count", 32'(word_count), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_re", 32'(Read_En), 0);
    check("t5_rst_data", 32'(out_data), 0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t5_re_c0", 32'(Read_En), 1);
    check("t5_valid_c0", 32'(out_valid), 0);
    tick();
    check("t5_valid_c1", 32'(out_valid), 0);
    tick();
    check("t5_valid_c2", 32'(out_valid), 1);
    check("t5_data_c2", 32'(out_data), 32'h43);
    tick();
    check("t5_data_c3", 32'(out_data), 32'h44);
    tick();
    check("t5_valid_c4", 32'(out_valid), 0);
    check("t5_count", 32'(word_count), 2);

    // Counter wrap with an endless source at full rate.
    do_reset();
    inf_mode = 1'b1;
    #1;
    repeat (65536) tick();
    check("t6_count_fffe", 32'(word_count), 32'hFFFE);
    tick();
    check("t6_count_ffff", 32'(word_count), 32'hFFFF);
    tick();
    check("t6_count_wrap", 32'(word_count), 32'h0000);
    tick();
    check("t6_count_one", 32'(word_count), 32'h0001);
    check("t6_busy", 32'(busy), 1);
    enable = 1'b0;
    inf_mode = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
